// File: rtl/adjacency_responder.sv
// Graph-edge server: returns start/end node indices, then streams each requested node's
// successor list from a CSR node table + edge memory. Optional ADJ_BOUNDS_CHECK_EN adds a sticky err flag.
module adjacency_responder #(
    parameter int PARAM_NODE_IDX_WIDTH = 10,
    parameter int PARAM_COUNTER_WIDTH  = 4,
    parameter int PARAM_EDGE_DEPTH     = 2048,
    localparam int NW = PARAM_NODE_IDX_WIDTH,
    localparam int CW = PARAM_COUNTER_WIDTH,
    localparam int EA = $clog2(PARAM_EDGE_DEPTH),
    localparam int AW = (NW > EA) ? NW : EA
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_run,
    input  logic [NW-1:0]   node_idx,
    input  logic            rd_next_node,
    output logic [NW-1:0]   next_node_idx,
    output logic [CW-1:0]   next_node_counter,
    input  logic            cfg_wr_en,
    input  logic [1:0]      cfg_sel,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [EA+CW-1:0] cfg_wdata,
    output logic            err
);

    // state  | meaning
    // IDLE   | configurable; waiting for start_run
    // START  | presenting start node index
    // END    | presenting end node index
    // LOOKUP | sampling node_idx / rd_next_node for the next list
    // STREAM | presenting successors, counter counts down to 1
    typedef enum logic [2:0] {
        IDLE, START, END, LOOKUP, STREAM
    } state_t;

    state_t state, state_d;

    logic [EA+CW-1:0] node_tbl [0:(1<<NW)-1];
    logic [NW-1:0]    edge_mem [0:PARAM_EDGE_DEPTH-1];

    logic [NW-1:0] start_reg, end_reg;
    logic [EA-1:0] ptr, ptr_d;
    logic [NW-1:0] idx_d;
    logic [CW-1:0] cnt_d;

    logic [EA+CW-1:0] tbl_entry;
    logic [EA-1:0]    tbl_base;
    logic [CW-1:0]    tbl_cnt;
    logic             cfg_ok;

    assign tbl_entry = node_tbl[node_idx];
    assign tbl_cnt   = tbl_entry[CW-1:0];
    assign tbl_base  = tbl_entry[CW +: EA];
    assign cfg_ok    = cfg_wr_en && !start_run && (state == IDLE);

    // Memories carry no reset so their contents survive rst_n.
    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_sel == 2'd0)
            node_tbl[cfg_addr[NW-1:0]] <= cfg_wdata;
        if (cfg_ok && cfg_sel == 2'd1)
            edge_mem[cfg_addr[EA-1:0]] <= cfg_wdata[NW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_reg <= '0;
            end_reg   <= '0;
        end else if (cfg_ok) begin
            if (cfg_sel == 2'd2) start_reg <= cfg_wdata[NW-1:0];
            if (cfg_sel == 2'd3) end_reg   <= cfg_wdata[NW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            next_node_idx     <= '0;
            next_node_counter <= '0;
            ptr               <= '0;
        end else begin
            state             <= state_d;
            next_node_idx     <= idx_d;
            next_node_counter <= cnt_d;
            ptr               <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = next_node_idx;
        cnt_d   = next_node_counter;
        ptr_d   = ptr;
        if (start_run) begin
            case (state)
                IDLE: begin
                    state_d = START;
                    idx_d   = start_reg;
                    cnt_d   = '0;
                end
                START: begin
                    state_d = END;
                    idx_d   = end_reg;
                end
                END: begin
                    state_d = LOOKUP;
                    cnt_d   = '0;
                end
                LOOKUP: begin
                    if (rd_next_node) begin
                        state_d = STREAM;
                        idx_d   = edge_mem[tbl_base];
                        cnt_d   = tbl_cnt;
                        ptr_d   = tbl_base + EA'(1);
                    end
                end
                STREAM: begin
                    if (next_node_counter > CW'(1)) begin
                        idx_d = edge_mem[ptr];
                        ptr_d = ptr + EA'(1);
                        cnt_d = next_node_counter - CW'(1);
                    end else begin
                        // Last successor (or empty list) consumed: index holds.
                        state_d = LOOKUP;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef ADJ_BOUNDS_CHECK_EN
    localparam logic [EA:0] DEPTH_W = PARAM_EDGE_DEPTH[EA:0];
    logic [EA:0] end_sum;
    logic        bad_entry;
    logic        err_q;

    assign end_sum   = {1'b0, tbl_base} + {{(EA+1-CW){1'b0}}, tbl_cnt};
    assign bad_entry = (tbl_cnt == '0) || (end_sum > DEPTH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (start_run && state == LOOKUP && rd_next_node && bad_entry)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adjacency_responder.sv
// Directed bench for adjacency_responder: start/end fetch, list streaming, stall, reset,
// config gating and (macro-dependent) err behaviour.
module tb_adjacency_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_run;
    logic [9:0]  node_idx;
    logic        rd_next_node;
    logic [9:0]  next_node_idx;
    logic [3:0]  next_node_counter;
    logic        cfg_wr_en;
    logic [1:0]  cfg_sel;
    logic [10:0] cfg_addr;
    logic [14:0] cfg_wdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ADJ_BOUNDS_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    adjacency_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_run         (start_run),
        .node_idx          (node_idx),
        .rd_next_node      (rd_next_node),
        .next_node_idx     (next_node_idx),
        .next_node_counter (next_node_counter),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_sel           (cfg_sel),
        .cfg_addr          (cfg_addr),
        .cfg_wdata         (cfg_wdata),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int idx, input int cnt);
        check({tag, ".idx"}, 32'(next_node_idx), 32'(idx));
        check({tag, ".cnt"}, 32'(next_node_counter), 32'(cnt));
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [10:0] addr, input logic [14:0] data);
        cfg_wr_en = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        start_run    = 1'b0;
        rd_next_node = 1'b0;
        rst_n        = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // IDLE -> START -> END -> LOOKUP with the given expected start/end indices.
    task automatic run_to_lookup(input string tag, input int s_idx, input int e_idx);
        start_run = 1'b1;
        step(); check_out({tag, ".start"}, s_idx, 0);
        step(); check_out({tag, ".end"}, e_idx, 0);
        step(); check_out({tag, ".lookup"}, e_idx, 0);
    endtask

    task automatic request(input int node);
        node_idx     = 10'(node);
        rd_next_node = 1'b1;
        step();
        rd_next_node = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_run = 1'b0; node_idx = '0; rd_next_node = 1'b0;
        cfg_wr_en = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 0, 0);
        check("reset.err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_write(2'd2, 11'd0, 15'd5);
        cfg_write(2'd3, 11'd0, 15'd9);
        cfg_write(2'd0, 11'd5, {11'd0, 4'd3});
        cfg_write(2'd0, 11'd7, {11'd3, 4'd1});
        cfg_write(2'd0, 11'd3, {11'd4, 4'd0});
        cfg_write(2'd0, 11'd4, {11'd2046, 4'd3});
        cfg_write(2'd1, 11'd0, 15'd7);
        cfg_write(2'd1, 11'd1, 15'd8);
        cfg_write(2'd1, 11'd2, 15'd9);
        cfg_write(2'd1, 11'd3, 15'd9);
        cfg_write(2'd1, 11'd4, 15'd11);
        cfg_write(2'd1, 11'd2046, 15'd21);
        cfg_write(2'd1, 11'd2047, 15'd22);
        check_out("idle_hold", 0, 0);

        run_to_lookup("run1", 5, 9);
        request(5);
        check_out("l5a", 7, 3);
        check("l5a.err", 32'(err), 0);
        step(); check_out("l5b", 8, 2);
        start_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_out("stall", 8, 2);
        end
        start_run = 1'b1;
        step(); check_out("l5c", 9, 1);
        step(); check_out("l5.lookup", 9, 0);
        request(7);
        check_out("l7", 9, 1);
        step(); check_out("l7.lookup", 9, 0);

        // Writes outside IDLE (running and stalled) must be ignored.
        cfg_write(2'd0, 11'd5, {11'd1, 4'd2});
        start_run = 1'b0;
        cfg_write(2'd0, 11'd5, {11'd1, 4'd2});
        start_run = 1'b1;
        check_out("gate.hold", 9, 0);
        request(5);
        check_out("gate.l5a", 7, 3);
        step(); check_out("gate.l5b", 8, 2);

        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0);
        start_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_to_lookup("run2", 0, 0);
        request(5);
        check_out("kept.l5a", 7, 3);
        step(); check_out("kept.l5b", 8, 2);
        step(); check_out("kept.l5c", 9, 1);

        do_reset();
        cfg_write(2'd0, 11'd5, {11'd1, 4'd2});
        cfg_write(2'd2, 11'd0, 15'd5);
        run_to_lookup("run3", 5, 0);
        request(5);
        check_out("new.l5a", 8, 2);
        step(); check_out("new.l5b", 9, 1);
        step(); check_out("new.lookup", 9, 0);

        do_reset();
        run_to_lookup("run4", 0, 0);
        request(3);
        check_out("zero", 11, 0);
        check("zero.err", 32'(err), 32'(ERR_EXP));
        step(); check_out("zero.lookup", 11, 0);
        check("zero.err_sticky", 32'(err), 32'(ERR_EXP));

        do_reset();
        check("rst.err", 32'(err), 0);
        run_to_lookup("run5", 0, 0);
        request(4);
        check_out("wrap.a", 21, 3);
        check("bounds.err", 32'(err), 32'(ERR_EXP));
        step(); check_out("wrap.b", 22, 2);
        step(); check_out("wrap.c", 7, 1);
        step(); check_out("wrap.lookup", 7, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
